// File: rtl/jtkcpu_intsync_pkg.sv
// Shared definitions for the CPU interrupt front end: vector addresses,
// condition-code bit positions, held-request source encoding, and the
// priority / vector helper functions used by the top level.
package jtkcpu_intsync_pkg;

    // Vector addresses presented to the sequencer
    localparam logic [15:0] VEC_NMI  = 16'hFFFC;
    localparam logic [15:0] VEC_FIRQ = 16'hFFF6;
    localparam logic [15:0] VEC_IRQ  = 16'hFFF8;
    localparam logic [15:0] VEC_RST  = 16'hFFFE;

    // Mask bit positions inside the CC register
    localparam int CC_F = 6;
    localparam int CC_I = 4;

    // Which source is currently held for the sequencer
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_NMI  = 2'd1,
        SRC_FIRQ = 2'd2,
        SRC_IRQ  = 2'd3
    } src_t;

    // Front-end sequencing state
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // Fixed priority: NMI over FIRQ over IRQ
    function automatic src_t arbitrate(input logic nmi_req,
                                       input logic firq_req,
                                       input logic irq_req);
        src_t win;
        win = SRC_NONE;
        if (nmi_req)       win = SRC_NMI;
        else if (firq_req) win = SRC_FIRQ;
        else if (irq_req)  win = SRC_IRQ;
        return win;
    endfunction

    // Vector address belonging to a held source; reset vector otherwise
    function automatic logic [15:0] vec_of(input src_t src);
        logic [15:0] vec;
        case (src)
            SRC_NMI:  vec = VEC_NMI;
            SRC_FIRQ: vec = VEC_FIRQ;
            SRC_IRQ:  vec = VEC_IRQ;
            default:  vec = VEC_RST;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/jtkcpu_intsync_if.sv
// Handshake between the interrupt front end and the microcode sequencer.
// The sequencer (master) drives the instruction-boundary strobe and the
// acknowledge; the front end (slave) drives the held request and vector.
interface jtkcpu_intsync_if;
    logic        ni;
    logic        int_ack;
    logic        nmi;
    logic        firq;
    logic        irq;
    logic [15:0] int_vec;
    logic        busy;

    modport master (
        output ni,
        output int_ack,
        input  nmi,
        input  firq,
        input  irq,
        input  int_vec,
        input  busy
    );

    modport slave (
        input  ni,
        input  int_ack,
        output nmi,
        output firq,
        output irq,
        output int_vec,
        output busy
    );
endinterface

// File: rtl/jtkcpu_sync.sv
// Multi-stage pin synchroniser. Resets to 1 so that active-low pins read
// as inactive until real samples have propagated through the chain.
// Runs on every clock edge; it is deliberately not gated by cen.
module jtkcpu_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    // Fewer than two stages gives no metastability protection
    localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [DEPTH-1:0] chain_reg;

    // Shift the asynchronous pin through the chain every clock
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg <= '1;
        end else begin
            chain_reg <= {chain_reg[DEPTH-2:0], din};
        end
    end

    assign dout = chain_reg[DEPTH-1];

endmodule

// File: rtl/jtkcpu_intsync.sv
// Interrupt front end for the CPU control block.
// Synchronises NMI/FIRQ/IRQ pins, detects the NMI falling edge, masks the
// level requests with CC, arbitrates and holds a single request plus its
// vector until the microcode sequencer acknowledges it.
// Optional build macro: JTKCPU_NMI_ARM_EN -- when defined, NMI stays
// disarmed after reset until the first nmi_arm pulse (stack pointer write);
// when undefined, NMI is live from reset and nmi_arm is ignored.
module jtkcpu_intsync
    import jtkcpu_intsync_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             nmi_n,
    input  logic             firq_n,
    input  logic             irq_n,
    input  logic [7:0]       cc,
    input  logic             nmi_arm,
    jtkcpu_intsync_if.slave  seq
);

    // Pin order inside the synchroniser bundle
    localparam int PIN_IRQ  = 0;
    localparam int PIN_FIRQ = 1;
    localparam int PIN_NMI  = 2;

    logic [2:0] pin_n;
    logic [2:0] pin_s;

    assign pin_n[PIN_IRQ]  = irq_n;
    assign pin_n[PIN_FIRQ] = firq_n;
    assign pin_n[PIN_NMI]  = nmi_n;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            jtkcpu_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk  (clk),
                .rst  (rst),
                .din  (pin_n[gi]),
                .dout (pin_s[gi])
            );
        end
    endgenerate

    logic nmi_s;
    logic firq_s;
    logic irq_s;

    assign nmi_s  = pin_s[PIN_NMI];
    assign firq_s = pin_s[PIN_FIRQ];
    assign irq_s  = pin_s[PIN_IRQ];

    // ------------------------------------------------------------------
    // NMI arming
    // ------------------------------------------------------------------
    logic nmi_armed;

`ifdef JTKCPU_NMI_ARM_EN
    logic nmi_armed_reg;

    // Arm once on the first stack-pointer write; only reset disarms
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_armed_reg <= 1'b0;
        end else if (cen && nmi_arm) begin
            nmi_armed_reg <= 1'b1;
        end
    end

    assign nmi_armed = nmi_armed_reg;
`else
    logic unused_nmi_arm;

    assign nmi_armed      = 1'b1;
    assign unused_nmi_arm = nmi_arm;
`endif

    // Only the two mask bits of CC matter here
    logic unused_cc;
    assign unused_cc = &{1'b0, cc[7], cc[5], cc[3:0]};

    // ------------------------------------------------------------------
    // NMI edge detector and pending latch
    // ------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    src_t        src_reg;
    src_t        src_next;
    logic [15:0] vec_reg;
    logic [15:0] vec_next;

    logic nmi_last_reg;
    logic nmi_pend_reg;
    logic nmi_pend_next;
    logic nmi_fall;
    logic nmi_ack;

    // A new edge beats a simultaneous acknowledge so no NMI is lost
    always_comb begin
        nmi_fall      = nmi_armed & nmi_last_reg & ~nmi_s;
        nmi_ack       = (state_reg == ST_SERVE) && (src_reg == SRC_NMI) && seq.int_ack;
        nmi_pend_next = nmi_pend_reg;
        if (nmi_fall) begin
            nmi_pend_next = 1'b1;
        end else if (nmi_ack) begin
            nmi_pend_next = 1'b0;
        end
    end

    // Edge history and pending flag advance only on clock enable
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_last_reg <= 1'b1;
            nmi_pend_reg <= 1'b0;
        end else if (cen) begin
            nmi_last_reg <= nmi_s;
            nmi_pend_reg <= nmi_pend_next;
        end
    end

    // ------------------------------------------------------------------
    // Masking, arbitration and request holding
    // ------------------------------------------------------------------
    logic firq_req;
    logic irq_req;
    src_t win_src;

    // Level requests are live, not latched: a released pin means no request
    always_comb begin
        firq_req = ~firq_s & ~cc[CC_F];
        irq_req  = ~irq_s  & ~cc[CC_I];
        win_src  = arbitrate(nmi_pend_reg, firq_req, irq_req);
    end

    // Next state: capture a winner at an instruction boundary, release on ack
    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        vec_next   = vec_reg;
        case (state_reg)
            ST_IDLE: begin
                if (seq.ni && (win_src != SRC_NONE)) begin
                    state_next = ST_SERVE;
                    src_next   = win_src;
                    vec_next   = vec_of(win_src);
                end
            end
            ST_SERVE: begin
                if (seq.int_ack) begin
                    state_next = ST_IDLE;
                    src_next   = SRC_NONE;
                    vec_next   = VEC_RST;
                end
            end
            default: begin
                state_next = ST_IDLE;
                src_next   = SRC_NONE;
                vec_next   = VEC_RST;
            end
        endcase
    end

    // State register; frozen while cen is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            src_reg   <= SRC_NONE;
            vec_reg   <= VEC_RST;
        end else if (cen) begin
            state_reg <= state_next;
            src_reg   <= src_next;
            vec_reg   <= vec_next;
        end
    end

    // Outputs decode straight from the held registers, so they stay constant in SERVE
    always_comb begin
        seq.busy    = (state_reg == ST_SERVE);
        seq.nmi     = (state_reg == ST_SERVE) && (src_reg == SRC_NMI);
        seq.firq    = (state_reg == ST_SERVE) && (src_reg == SRC_FIRQ);
        seq.irq     = (state_reg == ST_SERVE) && (src_reg == SRC_IRQ);
        seq.int_vec = vec_reg;
    end

endmodule

// File: tb/tb_jtkcpu_intsync.sv
// Self-checking bench for jtkcpu_intsync. Stimulus updates a reference
// model and queues the request it expects; a monitor checks the DUT
// outputs every cycle against the head of that queue.
module tb_jtkcpu_intsync;

    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic       nmi_n;
    logic       firq_n;
    logic       irq_n;
    logic [7:0] cc;
    logic       nmi_arm;

    jtkcpu_intsync_if seq_if ();

    jtkcpu_intsync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .nmi_n   (nmi_n),
        .firq_n  (firq_n),
        .irq_n   (irq_n),
        .cc      (cc),
        .nmi_arm (nmi_arm),
        .seq     (seq_if)
    );

    always #5 clk = ~clk;

    // Expected held request: one-hot {nmi,firq,irq} plus vector
    typedef struct {
        logic [2:0]  oh;
        logic [15:0] vec;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit       m_pend;
    bit       m_armed;
    bit       m_serving;
    bit [2:0] m_oh;

    bit mon_en    = 1'b0;
    bit busy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs must match the queued request while busy, be idle otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (seq_if.busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", {13'd0, seq_if.nmi, seq_if.firq, seq_if.irq, seq_if.int_vec},
                          {13'd0, 3'b000, 16'hFFFE});
                end else begin
                    check("held_req", {13'd0, seq_if.nmi, seq_if.firq, seq_if.irq, seq_if.int_vec},
                          {13'd0, exp_q[0].oh, exp_q[0].vec});
                end
            end else begin
                check("idle_out", {12'd0, seq_if.busy, seq_if.nmi, seq_if.firq, seq_if.irq, seq_if.int_vec},
                      {12'd0, 1'b0, 3'b000, 16'hFFFE});
                if (busy_prev && exp_q.size() > 0) begin
                    exp_t done;
                    done = exp_q.pop_front();
                    $display("served oh=%b vec=%h", done.oh, done.vec);
                end
            end
            busy_prev = (seq_if.busy === 1'b1);
        end
    end

    // Model: highest-priority eligible source, from the pin/CC rules
    function automatic bit [2:0] model_winner();
        if (m_pend)                      return 3'b100;
        if (firq_n == 1'b0 && !cc[6])    return 3'b010;
        if (irq_n == 1'b0 && !cc[4])     return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [15:0] model_vec(input bit [2:0] oh);
        case (oh)
            3'b100:  return 16'hFFFC;
            3'b010:  return 16'hFFF6;
            3'b001:  return 16'hFFF8;
            default: return 16'hFFFE;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cen = ($urandom_range(0, 3) != 0);
            cyc();
        end
        cen = 1'b1;
    endtask

    // Enough enabled cycles for pins to pass the synchroniser and edge detector
    task automatic settle();
        cen = 1'b1;
        repeat (SYNC_STAGES + 3) cyc();
    endtask

    task automatic set_pins(input logic f_n, input logic i_n, input logic [7:0] c);
        firq_n = f_n;
        irq_n  = i_n;
        cc     = c;
        $display("pins firq_n=%b irq_n=%b cc=%h", f_n, i_n, c);
        settle();
    endtask

    task automatic nmi_pulse();
        nmi_n = 1'b0;
        settle();
        nmi_n = 1'b1;
        settle();
        if (m_armed) m_pend = 1'b1;
        $display("nmi pulse armed=%0d pend=%0d", m_armed, m_pend);
    endtask

    task automatic arm();
        nmi_arm = 1'b1;
        cen     = 1'b1;
        cyc();
        nmi_arm = 1'b0;
`ifdef JTKCPU_NMI_ARM_EN
        m_armed = 1'b1;
`endif
        $display("nmi_arm armed=%0d", m_armed);
    endtask

    task automatic do_ni();
        bit [2:0] w;
        seq_if.ni = 1'b1;
        cen       = 1'b1;
        cyc();
        seq_if.ni = 1'b0;
        if (!m_serving) begin
            w = model_winner();
            if (w != 3'b000) begin
                exp_t e;
                e.oh  = w;
                e.vec = model_vec(w);
                exp_q.push_back(e);
                m_serving = 1'b1;
                m_oh      = w;
            end
        end
        $display("ni serving=%0d oh=%b", m_serving, m_oh);
        check("ni_busy", {31'd0, seq_if.busy}, {31'd0, m_serving});
    endtask

    task automatic do_ack();
        seq_if.int_ack = 1'b1;
        cen            = 1'b1;
        cyc();
        seq_if.int_ack = 1'b0;
        if (m_serving) begin
            if (m_oh == 3'b100) m_pend = 1'b0;
            m_serving = 1'b0;
            m_oh      = 3'b000;
        end
        $display("ack serving=%0d pend=%0d", m_serving, m_pend);
        check("ack_busy", {31'd0, seq_if.busy}, {31'd0, m_serving});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        m_pend    = 1'b0;
        m_serving = 1'b0;
        m_oh      = 3'b000;
`ifdef JTKCPU_NMI_ARM_EN
        m_armed = 1'b0;
`else
        m_armed = 1'b1;
`endif
        $display("reset");
        check("rst_out", {12'd0, seq_if.busy, seq_if.nmi, seq_if.firq, seq_if.irq, seq_if.int_vec},
              {12'd0, 1'b0, 3'b000, 16'hFFFE});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        cen            = 1'b1;
        nmi_n          = 1'b1;
        firq_n         = 1'b1;
        irq_n          = 1'b1;
        cc             = 8'h00;
        nmi_arm        = 1'b0;
        seq_if.ni      = 1'b0;
        seq_if.int_ack = 1'b0;
        repeat (3) cyc();
        do_reset();
        mon_en = 1'b1;
        settle();

        // Priority: FIRQ beats IRQ, IRQ follows after ack
        set_pins(1'b0, 1'b0, 8'h00);
        do_ni();
        do_ack();
        do_ni();
        do_ack();

        // Masking: both masked, then F/I cleared
        set_pins(1'b0, 1'b0, 8'h50);
        do_ni();
        do_ni();
        set_pins(1'b0, 1'b0, 8'h00);
        do_ni();
        do_ack();
        set_pins(1'b1, 1'b1, 8'h00);

        // Arming: edge before arm, then after arm
        nmi_pulse();
        do_ni();
        do_ack();
        arm();
        nmi_pulse();
        do_ni();
        do_ack();

        // NMI latched during IRQ service, served after pin returned high
        set_pins(1'b1, 1'b0, 8'h00);
        do_ni();
        nmi_pulse();
        do_ack();
        do_ni();
        do_ack();
        do_ack();

        // Hold stability in FIRQ service
        set_pins(1'b0, 1'b1, 8'h00);
        do_ni();
        set_pins(1'b1, 1'b1, 8'h40);
        do_ni();
        do_ni();
        do_ack();

        // Reset while serving IRQ with an NMI pending
        set_pins(1'b1, 1'b0, 8'h00);
        do_ni();
        nmi_pulse();
        do_reset();
        set_pins(1'b1, 1'b1, 8'h00);
        do_ni();
        nmi_pulse();
        do_ni();
        do_ack();
        arm();

        // Randomised mix against the model
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1: set_pins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
                2:    nmi_pulse();
                3:    arm();
                4, 5: do_ni();
                6, 7: do_ack();
                default: idle($urandom_range(1, 5));
            endcase
        end

        if (m_serving) do_ack();
        settle();
        check("queue_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
